// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one memory bus port between the instruction-fetch unit (IFU) and the
// load/store unit (LSU). Only one transaction is in flight at a time. Ties are
// broken round-robin. A response timeout turns a dead slave into an error
// response to the requester. Request payloads are muxed combinationally from
// the owner and are not registered.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // IFU side
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_rsp_valid,
    input  logic                  ifu_rsp_ready,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic                  ifu_rsp_err,
    // LSU side
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wmask,
    output logic                  lsu_rsp_valid,
    input  logic                  lsu_rsp_ready,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  lsu_rsp_err,
    // Memory bus side
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_rsp_valid,
    output logic                  mem_rsp_ready,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_rsp_err
);

    // Timeout counter width: enough to hold TIMEOUT, never narrower than 1 bit.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [TW-1:0] TSAT = {TW{1'b1}};
    localparam bit            TO_EN = (TIMEOUT != 0);

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t         state_r, state_s;
    logic           owner_r, owner_s;
    logic           last_grant_r, last_grant_s;
    logic [TW-1:0]  tcnt_r, tcnt_s;

    logic           own_req_valid_s;
    logic           own_rsp_ready_s;

    assign own_req_valid_s = (owner_r == OWN_LSU) ? lsu_req_valid : ifu_req_valid;
    assign own_rsp_ready_s = (owner_r == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;

    // State register: arbitration state, current owner, tie-break history, timeout count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_IFU;
            last_grant_r <= OWN_IFU;
            tcnt_r       <= '0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            last_grant_r <= last_grant_s;
            tcnt_r       <= tcnt_s;
        end
    end

    // Next-state logic: arbitration in IDLE, handshakes and timeout tracking elsewhere.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        last_grant_s = last_grant_r;
        tcnt_s       = tcnt_r;
        case (state_r)
            ST_IDLE: begin
                if (ifu_req_valid && lsu_req_valid) begin
                    // Tie: serve the unit that did not get the previous grant.
                    owner_s = ~last_grant_r;
                    state_s = ST_REQ;
                end else if (ifu_req_valid) begin
                    owner_s = OWN_IFU;
                    state_s = ST_REQ;
                end else if (lsu_req_valid) begin
                    owner_s = OWN_LSU;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (own_req_valid_s && mem_req_ready) begin
                    last_grant_s = owner_r;
                    tcnt_s       = '0;
                    state_s      = ST_RESP;
                end else if (!own_req_valid_s) begin
                    // Owner withdrew before the bus accepted; still counts for fairness.
                    last_grant_s = owner_r;
                    state_s      = ST_IDLE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_RESP: begin
                if (mem_rsp_valid) begin
                    // A response always wins over a timeout in the same cycle.
                    if (own_rsp_ready_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_RESP;
                    end
                end else begin
                    if (tcnt_r != TSAT) begin
                        tcnt_s = tcnt_r + TW'(1'b1);
                    end else begin
                        tcnt_s = tcnt_r;
                    end
                    if (TO_EN && (tcnt_r == TLIM)) begin
                        state_s = ST_ERR;
                    end else begin
                        state_s = ST_RESP;
                    end
                end
            end
            ST_ERR: begin
                if (own_rsp_ready_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ERR;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: route the owner's request to the bus and the bus response to the owner.
    always_comb begin
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rdata     = '0;
        ifu_rsp_err   = 1'b0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
        lsu_rdata     = '0;
        lsu_rsp_err   = 1'b0;
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        mem_wen       = 1'b0;
        mem_wdata     = '0;
        mem_wmask     = '0;
        mem_rsp_ready = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Swallow any stray or late bus response.
                mem_rsp_ready = 1'b1;
            end
            ST_REQ: begin
                mem_req_valid = own_req_valid_s;
                if (owner_r == OWN_LSU) begin
                    mem_addr      = lsu_addr;
                    mem_wen       = lsu_wen;
                    mem_wdata     = lsu_wdata;
                    mem_wmask     = lsu_wmask;
                    lsu_req_ready = mem_req_ready;
                end else begin
                    mem_addr      = ifu_addr;
                    ifu_req_ready = mem_req_ready;
                end
            end
            ST_RESP: begin
                mem_rsp_ready = own_rsp_ready_s;
                if (owner_r == OWN_LSU) begin
                    lsu_rsp_valid = mem_rsp_valid;
                    lsu_rdata     = mem_rdata;
                    lsu_rsp_err   = mem_rsp_err;
                end else begin
                    ifu_rsp_valid = mem_rsp_valid;
                    ifu_rdata     = mem_rdata;
                    ifu_rsp_err   = mem_rsp_err;
                end
            end
            ST_ERR: begin
                if (owner_r == OWN_LSU) begin
                    lsu_rsp_valid = 1'b1;
                    lsu_rsp_err   = 1'b1;
                end else begin
                    ifu_rsp_valid = 1'b1;
                    ifu_rsp_err   = 1'b1;
                end
            end
            default: begin
                mem_rsp_ready = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

    localparam int TMO = 4;

    logic        clk, rst_n;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int checks = 0;
    int errors = 0;

    // Model state: busy unit (0 none, 1 IFU, 2 LSU), request accepted, silent cycles, error pending
    int m_busy, m_last, m_wait;
    bit m_sent, m_err;
    bit ifu_hs_seen, lsu_hs_seen;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
        .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
        .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata),
        .mem_rsp_err(mem_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Bring the arbiter back to IDLE from any state and leave the bus quiet.
    task automatic drain;
        tick;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_err = 1'b0;
        tick;
        tick;
        mem_rsp_valid = 1'b0;
    endtask

    // Wait (bounded) until the IFU request handshake is visible.
    task automatic wait_ifu_hs(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ifu_req_valid && ifu_req_ready) && n < 10);
        chk(nm, (ifu_req_valid && ifu_req_ready), 1'b1);
    endtask

    // Compare process: every cycle check DUT against the model, then advance the model.
    initial begin
        logic e_mrv, e_mrr, e_irr, e_lrr, e_irv, e_lrv, e_ierr, e_lerr, e_wen;
        logic [31:0] e_addr, e_wdata, e_ird, e_lrd;
        logic [3:0]  e_wmask;
        bit own_v, own_r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_last = 1; m_wait = 0; m_sent = 1'b0; m_err = 1'b0;
            end
            e_mrv = 0; e_mrr = 0; e_irr = 0; e_lrr = 0; e_irv = 0; e_lrv = 0;
            e_ierr = 0; e_lerr = 0; e_wen = 0;
            e_addr = '0; e_wdata = '0; e_ird = '0; e_lrd = '0; e_wmask = '0;
            own_v = (m_busy == 1) ? ifu_req_valid : lsu_req_valid;
            own_r = (m_busy == 1) ? ifu_rsp_ready : lsu_rsp_ready;
            if (m_busy == 0) begin
                e_mrr = 1;
            end else if (!m_sent) begin
                e_mrv = own_v;
                if (m_busy == 1) begin
                    e_addr = ifu_addr; e_irr = mem_req_ready;
                end else begin
                    e_addr = lsu_addr; e_wen = lsu_wen; e_wdata = lsu_wdata;
                    e_wmask = lsu_wmask; e_lrr = mem_req_ready;
                end
            end else if (!m_err) begin
                e_mrr = own_r;
                if (m_busy == 1) begin
                    e_irv = mem_rsp_valid; e_ird = mem_rdata; e_ierr = mem_rsp_err;
                end else begin
                    e_lrv = mem_rsp_valid; e_lrd = mem_rdata; e_lerr = mem_rsp_err;
                end
            end else begin
                if (m_busy == 1) begin
                    e_irv = 1; e_ierr = 1;
                end else begin
                    e_lrv = 1; e_lerr = 1;
                end
            end
            chk("m_mem_req_valid", mem_req_valid, e_mrv);
            chk("m_mem_rsp_ready", mem_rsp_ready, e_mrr);
            chk("m_mem_addr", mem_addr, e_addr);
            chk("m_mem_wen", mem_wen, e_wen);
            chk("m_mem_wdata", mem_wdata, e_wdata);
            chk("m_mem_wmask", mem_wmask, e_wmask);
            chk("m_ifu_req_ready", ifu_req_ready, e_irr);
            chk("m_lsu_req_ready", lsu_req_ready, e_lrr);
            chk("m_ifu_rsp_valid", ifu_rsp_valid, e_irv);
            chk("m_ifu_rdata", ifu_rdata, e_ird);
            chk("m_ifu_rsp_err", ifu_rsp_err, e_ierr);
            chk("m_lsu_rsp_valid", lsu_rsp_valid, e_lrv);
            chk("m_lsu_rdata", lsu_rdata, e_lrd);
            chk("m_lsu_rsp_err", lsu_rsp_err, e_lerr);
            ifu_hs_seen = ifu_req_valid && ifu_req_ready;
            lsu_hs_seen = lsu_req_valid && lsu_req_ready;
            if (rst_n) begin
                if (m_busy == 0) begin
                    if (ifu_req_valid && lsu_req_valid) m_busy = (m_last == 2) ? 1 : 2;
                    else if (ifu_req_valid) m_busy = 1;
                    else if (lsu_req_valid) m_busy = 2;
                end else if (!m_sent) begin
                    if (own_v && mem_req_ready) begin
                        m_sent = 1'b1; m_wait = 0; m_last = m_busy;
                    end else if (!own_v) begin
                        m_last = m_busy; m_busy = 0;
                    end
                end else if (!m_err) begin
                    if (mem_rsp_valid) begin
                        if (own_r) begin m_busy = 0; m_sent = 1'b0; end
                    end else begin
                        m_wait++;
                        if (m_wait >= TMO) m_err = 1'b1;
                    end
                end else begin
                    if (own_r) begin m_busy = 0; m_sent = 1'b0; m_err = 1'b0; end
                end
            end
        end
    end

    // Stimulus: directed scenarios with literal expectations, then random traffic.
    initial begin
        int grants[4];
        int ng, n, silent;
        rst_n = 1'b0;
        ifu_req_valid = 0; ifu_addr = '0; ifu_rsp_ready = 0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0; lsu_rsp_ready = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0; mem_rsp_err = 0;
        repeat (2) @(negedge clk);
        chk("rst_mem_rsp_ready", mem_rsp_ready, 1'b1);
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        tick; rst_n = 1'b1;

        // IFU-only read
        tick;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1; ifu_rsp_ready = 1;
        @(negedge clk); chk("ifu_c0_req_valid", mem_req_valid, 1'b0);
        tick; @(negedge clk);
        chk("ifu_c1_req_valid", mem_req_valid, 1'b1);
        chk("ifu_c1_addr", mem_addr, 32'h8000_0000);
        chk("ifu_c1_lsu_ready", lsu_req_ready, 1'b0);
        tick; ifu_req_valid = 0; mem_req_ready = 0;
        @(negedge clk); chk("ifu_c2_rsp_valid", ifu_rsp_valid, 1'b0);
        tick; mem_rsp_valid = 1; mem_rdata = 32'h0000_0413;
        @(negedge clk);
        chk("ifu_c3_rsp_valid", ifu_rsp_valid, 1'b1);
        chk("ifu_c3_rdata", ifu_rdata, 32'h0000_0413);
        chk("ifu_c3_err", ifu_rsp_err, 1'b0);
        tick; mem_rsp_valid = 0;
        @(negedge clk);
        chk("ifu_c4_idle", mem_rsp_ready, 1'b1);
        chk("ifu_c4_rsp_valid", ifu_rsp_valid, 1'b0);

        // Simultaneous requests: strict alternation starting with LSU, LSU is a store
        tick;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
        lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        mem_req_ready = 1; mem_rsp_valid = 1; mem_rdata = 32'h1234_5678;
        ifu_rsp_ready = 1; lsu_rsp_ready = 1;
        ng = 0;
        for (int k = 0; k < 16 && ng < 4; k++) begin
            @(negedge clk);
            if (mem_req_valid && mem_req_ready) begin
                if (lsu_req_ready && !ifu_req_ready) grants[ng] = 2;
                else if (ifu_req_ready && !lsu_req_ready) grants[ng] = 1;
                else grants[ng] = 0;
                if (ng == 0) begin
                    chk("st_wen", mem_wen, 1'b1);
                    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
                    chk("st_wmask", mem_wmask, 4'hF);
                    chk("st_addr", mem_addr, 32'h8000_1000);
                end
                ng++;
            end
        end
        chk("tie_count", ng, 4);
        chk("tie_g0_lsu", grants[0], 2);
        chk("tie_g1_ifu", grants[1], 1);
        chk("tie_g2_lsu", grants[2], 2);
        chk("tie_g3_ifu", grants[3], 1);
        drain;

        // Timeout: bus never answers
        ifu_req_valid = 1; ifu_addr = 32'h8000_0100; mem_req_ready = 1; ifu_rsp_ready = 0;
        wait_ifu_hs("to_req_hs");
        tick; ifu_req_valid = 0; mem_req_ready = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifu_rsp_valid && n < 20);
        chk("to_latency", n, 5);
        chk("to_err", ifu_rsp_err, 1'b1);
        chk("to_rdata", ifu_rdata, 32'h0);
        chk("to_lsu_rsp", lsu_rsp_valid, 1'b0);
        tick; @(negedge clk); chk("to_err_hold", ifu_rsp_valid, 1'b1);
        tick; ifu_rsp_ready = 1;
        tick; ifu_rsp_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("late_ifu", ifu_rsp_valid, 1'b0);
        chk("late_lsu", lsu_rsp_valid, 1'b0);
        chk("late_absorb", mem_rsp_ready, 1'b1);
        tick; mem_rsp_valid = 0;

        // Response arriving in the timeout cycle wins
        ifu_req_valid = 1; mem_req_ready = 1; ifu_rsp_ready = 1;
        wait_ifu_hs("edge_req_hs");
        tick; ifu_req_valid = 0; mem_req_ready = 0;
        @(negedge clk);
        tick; @(negedge clk);
        tick; @(negedge clk);
        tick; mem_rsp_valid = 1; mem_rsp_err = 1; mem_rdata = 32'h0000_00AA;
        @(negedge clk);
        chk("edge_rsp_valid", ifu_rsp_valid, 1'b1);
        chk("edge_rsp_err", ifu_rsp_err, 1'b1);
        chk("edge_rdata", ifu_rdata, 32'h0000_00AA);
        tick; mem_rsp_valid = 0; mem_rsp_err = 0;
        @(negedge clk);
        chk("edge_no_err_state", ifu_rsp_valid, 1'b0);
        chk("edge_idle", mem_rsp_ready, 1'b1);

        // Backpressure then withdrawal
        tick; lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_2000; mem_req_ready = 0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            tick; @(negedge clk);
            chk("bp_req_valid", mem_req_valid, 1'b1);
        end
        tick; lsu_req_valid = 0;
        @(negedge clk); chk("wd_req_valid", mem_req_valid, 1'b0);
        tick; @(negedge clk); chk("wd_idle", mem_rsp_ready, 1'b1);

        // Async reset in RESP
        tick; ifu_req_valid = 1; mem_req_ready = 1; ifu_rsp_ready = 0;
        wait_ifu_hs("ar_req_hs");
        tick; ifu_req_valid = 0; mem_req_ready = 0; mem_rsp_valid = 1;
        @(negedge clk); chk("ar_pre_rsp", ifu_rsp_valid, 1'b1);
        @(posedge clk); #2; rst_n = 1'b0; #1;
        chk("ar_rsp_valid", ifu_rsp_valid, 1'b0);
        chk("ar_req_valid", mem_req_valid, 1'b0);
        chk("ar_rsp_ready", mem_rsp_ready, 1'b1);
        mem_rsp_valid = 0;
        tick; rst_n = 1'b1;
        ifu_req_valid = 1; lsu_req_valid = 1; mem_req_ready = 1;
        @(negedge clk);
        tick; @(negedge clk);
        chk("ar_tie_lsu", lsu_req_ready, 1'b1);
        chk("ar_tie_ifu", ifu_req_ready, 1'b0);
        drain;

        // Random traffic
        silent = 0;
        for (int c = 0; c < 4000; c++) begin
            tick;
            if (ifu_req_valid && !ifu_hs_seen) begin
                if ($urandom_range(0, 19) == 0) ifu_req_valid = 0;
            end else begin
                ifu_req_valid = $urandom_range(0, 1) == 1;
                ifu_addr = $urandom;
            end
            if (lsu_req_valid && !lsu_hs_seen) begin
                if ($urandom_range(0, 19) == 0) lsu_req_valid = 0;
            end else begin
                lsu_req_valid = $urandom_range(0, 1) == 1;
                lsu_addr = $urandom; lsu_wen = $urandom_range(0, 1) == 1;
                lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
            end
            mem_req_ready = $urandom_range(0, 2) != 0;
            ifu_rsp_ready = $urandom_range(0, 3) != 0;
            lsu_rsp_ready = $urandom_range(0, 3) != 0;
            if (silent > 0) begin
                silent--;
                mem_rsp_valid = 0;
            end else begin
                mem_rsp_valid = $urandom_range(0, 2) == 0;
                if ($urandom_range(0, 15) == 0) silent = $urandom_range(3, 8);
            end
            mem_rdata = $urandom;
            mem_rsp_err = $urandom_range(0, 7) == 0;
        end
        drain;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory bus port between the instruction-fetch unit (IFU) and the load/store unit (LSU) of the ysyx_23060184 core.
- Transactions are non-overlapping: one request, then one response, at a time.
- When both units request together, the grant alternates between them (round-robin).
- A response timeout returns an error to the requester so the core does not hang on a dead slave.
- Sits between IFU/LSU and the memory/bus bridge. The LSU-side controls (wen, wmask) come from the decoded MemWrite/Wmask path.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, cycles to wait in RESP for mem_rsp_valid before an error response is generated; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted.
- ifu_addr  in  ADDR_W  IFU address.
- ifu_rsp_valid  out  1  IFU response valid.
- ifu_rsp_ready  in  1  IFU accepts the response.
- ifu_rdata  out  DATA_W  IFU read data.
- ifu_rsp_err  out  1  IFU response error.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wen  in  1  1 = write, 0 = read.
- lsu_wdata  in  DATA_W  LSU write data.
- lsu_wmask  in  DATA_W/8  LSU byte write mask.
- lsu_rsp_valid  out  1  LSU response valid.
- lsu_rsp_ready  in  1  LSU accepts the response.
- lsu_rdata  out  DATA_W  LSU read data.
- lsu_rsp_err  out  1  LSU response error.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus accepts the request.
- mem_addr  out  ADDR_W  bus address.
- mem_wen  out  1  bus write enable.
- mem_wdata  out  DATA_W  bus write data.
- mem_wmask  out  DATA_W/8  bus byte mask.
- mem_rsp_valid  in  1  bus response valid.
- mem_rsp_ready  out  1  bus response accepted.
- mem_rdata  in  DATA_W  bus read data.
- mem_rsp_err  in  1  bus response error.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, owner=IFU, last_grant=IFU, tcnt=0.
  - All valid/ready outputs 0 except mem_rsp_ready=1 (IDLE value).
  - Data outputs 0.
- State registers: state {IDLE, REQ, RESP, ERR}, owner (1 bit), last_grant (1 bit), tcnt ($clog2(TIMEOUT+1) bits, minimum 1).
- IDLE:
  - Samples ifu_req_valid and lsu_req_valid.
  - Only one valid: that unit becomes owner; next state REQ.
  - Both valid: owner = the unit opposite last_grant (after reset the first tie goes to LSU); next state REQ.
  - Neither valid: stay in IDLE.
  - mem_rsp_ready=1 in IDLE; any stray or late mem response is consumed and discarded.
  - No requester output is asserted in IDLE.
- Request latency: mem_req_valid rises exactly 1 cycle after the owner's req_valid is first seen in IDLE.
- REQ:
  - mem_req_valid = owner req_valid.
  - mem_addr, mem_wen, mem_wdata, mem_wmask are muxed combinationally from the owner. For an IFU grant: mem_wen=0, mem_wdata=0, mem_wmask=0.
  - Owner req_ready = mem_req_ready; non-owner req_ready=0; mem_rsp_ready=0.
  - Handshake (mem_req_valid & mem_req_ready): last_grant<=owner, tcnt<=0, next state RESP.
  - Owner drops req_valid before the handshake (withdrawal): next state IDLE, last_grant<=owner.
- RESP:
  - Owner rsp_valid = mem_rsp_valid; owner rdata/err = mem_rdata/mem_rsp_err.
  - mem_rsp_ready = owner rsp_ready.
  - Non-owner rsp_valid=0, rdata=0, err=0.
  - Handshake: next state IDLE.
  - If mem_rsp_valid=0: tcnt increments, saturating. When TIMEOUT!=0 and tcnt==TIMEOUT-1 with no mem_rsp_valid, next state ERR.
  - Both conditions in the same cycle: a response that arrives in the timeout cycle wins over the timeout.
- ERR:
  - Owner rsp_valid=1, err=1, rdata=0; mem_rsp_ready=0.
  - Owner rsp_ready=1: next state IDLE; the late bus response is then dropped in IDLE.
- Response delivery: at most one response per request, delivered to the owner only.
- Requester rules: req fields stay stable while req_valid=1 and req_ready=0; the arbiter does not register request payloads.
- Reset mid-transaction: the transaction is abandoned with no response to either unit; the bus sees mem_req_valid=0 immediately.
- No combinational path from any rsp_ready input to any req_ready output.

Test Plan:
- IFU-only read: ifu_req_valid=1 at cycle 0, addr 0x80000000; bus ready at cycle 1, rsp at cycle 3 with rdata 0x00000413 -> mem_req_valid rises at cycle 1; ifu_rsp_valid=1, ifu_rdata=0x00000413, err=0 at cycle 3; state back to IDLE at cycle 4.
- Simultaneous requests after reset: both valid at cycle 0 -> LSU served first. Both still valid afterwards -> IFU served next, then LSU (strict alternation over 4 transactions). Non-owner req_ready never 1.
- LSU store: lsu_wen=1, addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF -> mem_wen=1, mem_wmask=0xF, mem_wdata=0xDEADBEEF during REQ. ifu_rsp_valid stays 0 throughout.
- Timeout: TIMEOUT=4, bus never responds -> exactly 4 cycles after entering RESP the owner sees rsp_valid=1, err=1, rdata=0. A late mem_rsp_valid in IDLE is absorbed; no rsp_valid reaches either unit.
- Backpressure and withdrawal: mem_req_ready=0 for 5 cycles holds REQ and mem_req_valid=1. Owner withdrawal in REQ returns to IDLE next cycle. Response arriving exactly in the timeout cycle is delivered with err=mem_rsp_err, with no ERR state.
- Async reset asserted in RESP -> all valid outputs 0 within the same cycle, mem_rsp_ready=1. After release, the first tie goes to LSU.
